reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 38 +++
 rtl/reg_writeback.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: groups the writeback-stage traffic (ALU result, long-latency
// result handshake, issue/decode hazard lookup and register-file write port).
// The slave modport is the writeback block; the master modport is its environment.
interface reg_writeback_if;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_RA;
  logic [4:0]  i_RB;
  logic        o_stall;
  logic        o_alu_hold;
  logic [4:0]  o_RW;
  logic [31:0] o_BusW;
  logic        o_RegWrite;
  logic        o_err;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lu_valid, i_lu_rd, i_lu_data,
    output o_lu_ready,
    input  i_issue_valid, i_issue_rd, i_RA, i_RB,
    output o_stall, o_alu_hold, o_RW, o_BusW, o_RegWrite, o_err
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lu_valid, i_lu_rd, i_lu_data,
    input  o_lu_ready,
    output i_issue_valid, i_issue_rd, i_RA, i_RB,
    input  o_stall, o_alu_hold, o_RW, o_BusW, o_RegWrite, o_err
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: single register-file write port shared by a single-cycle ALU
// path and a buffered long-latency path. The ALU has priority; a starvation
// counter periodically holds the ALU so buffered results always drain. A
// pending scoreboard tracks issued long-latency destinations for decode stalls.
module reg_writeback #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 3
) (
  input logic            i_clk,
  input logic            i_rst_n,
  reg_writeback_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM + 1) : 1;

  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STV_ONE     = SW'(1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIM - 1);

  // Result buffer storage and control state
  logic [4:0]    fifo_rd_r   [FIFO_DEPTH];
  logic [31:0]   fifo_data_r [FIFO_DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] starve_r;
  logic          hold_r;
  logic          err_r;
  logic [31:0]   pending_r;

  // Registered write port
  logic          regwrite_r;
  logic [4:0]    rw_r;
  logic [31:0]   busw_r;

  // Per-cycle decisions
  logic          full_s;
  logic          empty_s;
  logic          lu_ready_s;
  logic          push_s;
  logic          alu_sel_s;
  logic          alu_drop_s;
  logic          pop_s;
  logic [4:0]    head_rd_s;
  logic [31:0]   head_data_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   clr_mask_s;
  logic [31:0]   pending_nxt_s;
  logic          stall_s;

  // Buffer status, handshake and write-slot arbitration
  always_comb begin
    full_s      = (count_r == CNT_FULL);
    empty_s     = (count_r == {CW{1'b0}});
    // Ready is forced low while reset is asserted; a full buffer never
    // accepts, even if the head is popped in the same cycle.
    lu_ready_s  = i_rst_n && !full_s;
    // rd=0 results complete the handshake but are not stored.
    push_s      = bus.i_lu_valid && lu_ready_s && (bus.i_lu_rd != 5'd0);
    alu_sel_s   = !hold_r && bus.i_alu_valid && (bus.i_alu_rd != 5'd0);
    alu_drop_s  = hold_r && bus.i_alu_valid && (bus.i_alu_rd != 5'd0);
    pop_s       = !alu_sel_s && !empty_s;
    head_rd_s   = fifo_rd_r[rptr_r];
    head_data_s = fifo_data_r[rptr_r];
  end

  // Scoreboard next state: clear on buffered write, set on issue, set wins
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) begin
      set_mask_s[bus.i_issue_rd] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (pop_s) begin
      clr_mask_s[head_rd_s] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
    // Register 0 is never tracked.
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Decode hazard check against the pending scoreboard
  always_comb begin
    stall_s = ((bus.i_RA != 5'd0) && pending_r[bus.i_RA]) ||
              ((bus.i_RB != 5'd0) && pending_r[bus.i_RB]);
  end

  // Buffer storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_rd_r[wptr_r]   <= bus.i_lu_rd;
        fifo_data_r[wptr_r] <= bus.i_lu_data;
        wptr_r              <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter and one-cycle ALU hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_r <= {SW{1'b0}};
      hold_r   <= 1'b0;
    end else if (!empty_s && !pop_s) begin
      // The edge on which the count would reach the limit raises the hold
      // for the following cycle, whose forced pop restarts the count.
      if (starve_r == STARVE_LAST) begin
        hold_r   <= 1'b1;
        starve_r <= {SW{1'b0}};
      end else begin
        hold_r   <= 1'b0;
        starve_r <= starve_r + STV_ONE;
      end
    end else begin
      hold_r   <= 1'b0;
      starve_r <= {SW{1'b0}};
    end
  end

  // Pending scoreboard and sticky protocol error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (alu_drop_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Registered register-file write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regwrite_r <= 1'b0;
      rw_r       <= 5'd0;
      busw_r     <= 32'd0;
    end else if (alu_sel_s) begin
      regwrite_r <= 1'b1;
      rw_r       <= bus.i_alu_rd;
      busw_r     <= bus.i_alu_data;
    end else if (pop_s) begin
      regwrite_r <= 1'b1;
      rw_r       <= head_rd_s;
      busw_r     <= head_data_s;
    end else begin
      regwrite_r <= 1'b0;
      rw_r       <= 5'd0;
      busw_r     <= 32'd0;
    end
  end

  assign bus.o_lu_ready = lu_ready_s;
  assign bus.o_stall    = stall_s;
  assign bus.o_alu_hold = hold_r;
  assign bus.o_RW       = rw_r;
  assign bus.o_BusW     = busw_r;
  assign bus.o_RegWrite = regwrite_r;
  assign bus.o_err      = err_r;

endmodule
